vga_sync_gen: RTL and testbench

Free-running VGA timing generator that drives the HSync/VSync pair consumed by the game top. It also produces column/row counters, an active-video flag and frame/line start strobes from one clock. It replaces the external sync source, so `sync_to_count` and the game logic receive syncs generated on-chip. The sync outputs can be delayed by a fixed number of pixels to line up with a registered video pipeline.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/sync_axis_counter.sv | 45 ++++
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and the types used by the VGA sync generator.
package vga_timing_pkg;

  localparam int unsigned COUNT_W = 10;

  localparam int unsigned DEF_TOTAL_COLS    = 800;
  localparam int unsigned DEF_TOTAL_ROWS    = 525;
  localparam int unsigned DEF_ACTIVE_COLS   = 640;
  localparam int unsigned DEF_ACTIVE_ROWS   = 480;
  localparam int unsigned DEF_H_FRONT_PORCH = 16;
  localparam int unsigned DEF_H_SYNC_WIDTH  = 96;
  localparam int unsigned DEF_V_FRONT_PORCH = 10;
  localparam int unsigned DEF_V_SYNC_WIDTH  = 2;

  typedef enum logic {
    GEN_PRIME,
    GEN_RUN
  } gen_state_t;

  // Sync flags are carried active-high internally; polarity is applied at the pins.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } vid_flags_t;

endpackage

// File: rtl/sync_axis_counter.sv
// One timing axis: modulo counter with terminal count, plus active and sync window
// decodes evaluated on the value the counter takes at the next clock.
module sync_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = DEF_TOTAL_COLS,
  parameter int unsigned ACTIVE     = DEF_ACTIVE_COLS,
  parameter int unsigned SYNC_START = DEF_ACTIVE_COLS + DEF_H_FRONT_PORCH,
  parameter int unsigned SYNC_WIDTH = DEF_H_SYNC_WIDTH
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Advance,
  output logic [COUNT_W-1:0] o_Count,
  output logic               o_Terminal,
  output logic               o_Next_Active,
  output logic               o_Next_Sync
);

  localparam logic [COUNT_W-1:0] LAST    = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACT_END = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] SYNC_LO = COUNT_W'(SYNC_START);
  localparam logic [COUNT_W-1:0] SYNC_HI = COUNT_W'(SYNC_START + SYNC_WIDTH);

  logic [COUNT_W-1:0] next_count;

  always_comb begin
    o_Terminal = (o_Count == LAST);
    next_count = o_Count;
    if (i_Advance) begin
      next_count = o_Terminal ? '0 : o_Count + 1'b1;
    end
    o_Next_Active = (next_count < ACT_END);
    o_Next_Sync   = (next_count >= SYNC_LO) && (next_count < SYNC_HI);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_Count <= '0;
    end else begin
      o_Count <= next_count;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: counters, registered syncs/active/strobes,
// and an optional enable-gated delay line on the sync and active outputs.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL_COLS      = DEF_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS      = DEF_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS     = DEF_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS     = DEF_ACTIVE_ROWS,
  parameter int unsigned H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
  parameter int unsigned V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned SYNC_DELAY      = 0
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Enable,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [COUNT_W-1:0] o_Col_Count,
  output logic [COUNT_W-1:0] o_Row_Count,
  output logic               o_Active,
  output logic               o_Line_Start,
  output logic               o_Frame_Start
);

  gen_state_t state;
  logic       col_adv, row_adv;
  logic       col_term, row_term;
  logic       col_next_act, row_next_act;
  logic       col_next_sync, row_next_sync;
  logic       enter_line, enter_frame;
  vid_flags_t pipe [SYNC_DELAY+1];

  // After reset the first enable only enters (0,0) so that position gets its strobes.
  assign col_adv = i_Enable && (state == GEN_RUN);
  assign row_adv = col_adv && col_term;

  assign enter_line  = i_Enable && ((state == GEN_PRIME) || col_term);
  assign enter_frame = enter_line && ((state == GEN_PRIME) || row_term);

  sync_axis_counter #(
    .TOTAL      (TOTAL_COLS),
    .ACTIVE     (ACTIVE_COLS),
    .SYNC_START (ACTIVE_COLS + H_FRONT_PORCH),
    .SYNC_WIDTH (H_SYNC_WIDTH)
  ) u_col (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Advance     (col_adv),
    .o_Count       (o_Col_Count),
    .o_Terminal    (col_term),
    .o_Next_Active (col_next_act),
    .o_Next_Sync   (col_next_sync)
  );

  sync_axis_counter #(
    .TOTAL      (TOTAL_ROWS),
    .ACTIVE     (ACTIVE_ROWS),
    .SYNC_START (ACTIVE_ROWS + V_FRONT_PORCH),
    .SYNC_WIDTH (V_SYNC_WIDTH)
  ) u_row (
    .i_Clk         (i_Clk),
    .i_Rst         (i_Rst),
    .i_Advance     (row_adv),
    .o_Count       (o_Row_Count),
    .o_Terminal    (row_term),
    .o_Next_Active (row_next_act),
    .o_Next_Sync   (row_next_sync)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= GEN_PRIME;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
      for (int unsigned i = 0; i <= SYNC_DELAY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      o_Line_Start  <= enter_line;
      o_Frame_Start <= enter_frame;
      if (i_Enable) begin
        state   <= GEN_RUN;
        pipe[0] <= '{hsync: col_next_sync, vsync: row_next_sync,
                     active: col_next_act && row_next_act};
        for (int unsigned i = 1; i <= SYNC_DELAY; i++) begin
          pipe[i] <= pipe[i-1];
        end
      end
    end
  end

  assign o_HSync  = pipe[SYNC_DELAY].hsync ^ SYNC_ACTIVE_LOW;
  assign o_VSync  = pipe[SYNC_DELAY].vsync ^ SYNC_ACTIVE_LOW;
  assign o_Active = pipe[SYNC_DELAY].active;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed checks of vga_sync_gen: default timing, delayed-sync variant, and a
// shrunk active-high variant used for whole-frame properties.
module tb_vga_sync_gen;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Enable = 1'b1;

  logic       hs0, vs0, act0, ls0, fs0;
  logic [9:0] col0, row0;
  logic       hs1, vs1, act1, ls1, fs1;
  logic [9:0] col1, row1;
  logic       hs2, vs2, act2, ls2, fs2;
  logic [9:0] col2, row2;

  int errors = 0;
  int checks = 0;

  always #5 i_Clk = ~i_Clk;

  vga_sync_gen u_dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable),
    .o_HSync(hs0), .o_VSync(vs0), .o_Col_Count(col0), .o_Row_Count(row0),
    .o_Active(act0), .o_Line_Start(ls0), .o_Frame_Start(fs0)
  );

  vga_sync_gen #(
    .TOTAL_COLS(20), .TOTAL_ROWS(12), .ACTIVE_COLS(12), .ACTIVE_ROWS(8),
    .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2),
    .SYNC_ACTIVE_LOW(1'b0), .SYNC_DELAY(0)
  ) u_small (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable),
    .o_HSync(hs1), .o_VSync(vs1), .o_Col_Count(col1), .o_Row_Count(row1),
    .o_Active(act1), .o_Line_Start(ls1), .o_Frame_Start(fs1)
  );

  vga_sync_gen #(.SYNC_DELAY(2)) u_dly (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable),
    .o_HSync(hs2), .o_VSync(vs2), .o_Col_Count(col2), .o_Row_Count(row2),
    .o_Active(act2), .o_Line_Start(ls2), .o_Frame_Start(fs2)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic en);
    i_Enable = en;
    @(posedge i_Clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs_cnt = 0, hs_first = -1, hs_last = -1, act_fall = -1, ls_cnt = 0;
    int hs2_first = -1, hs2_last = -1, act2_rise = -1, act2_fall = -1;
    int s_period = 0, s_vs_cnt = 0, s_vs_col = -1, s_vs_row = -1;
    int s_wrap_col = -1, s_wrap_row = -1, s_hs_first = -1, s_hs_last = -1;
    int s_prev_col = 0, s_prev_row = 0;
    logic prev_act0, prev_act2;

    // Reset held with enable high: reset wins.
    step(1);
    step(1);
    check("rst_col", col0, 0);
    check("rst_row", row0, 0);
    check("rst_hs", hs0, 1);
    check("rst_vs", vs0, 1);
    check("rst_act", act0, 0);
    check("rst_ls", ls0, 0);
    check("rst_fs", fs0, 0);
    check("rst_hs_hi_pol", hs1, 0);
    check("rst_dly_act", act2, 0);

    i_Rst = 1'b0;
    step(1);
    check("first_col", col0, 0);
    check("first_row", row0, 0);
    check("first_hs", hs0, 1);
    check("first_vs", vs0, 1);
    check("first_act", act0, 1);
    check("first_ls", ls0, 1);
    check("first_fs", fs0, 1);
    check("first_dly_fs", fs2, 1);
    check("first_dly_act", act2, 0);
    check("first_small_fs", fs1, 1);

    prev_act0 = act0;
    prev_act2 = act2;
    for (int i = 1; i <= 800; i++) begin
      step(1);
      if (!hs0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(col0);
        hs_last = int'(col0);
      end
      if (prev_act0 && !act0) act_fall = int'(col0);
      if (ls0) ls_cnt++;
      if (!hs2) begin
        if (hs2_first < 0) hs2_first = int'(col2);
        hs2_last = int'(col2);
      end
      if (!prev_act2 && act2 && act2_rise < 0) act2_rise = int'(col2);
      if (prev_act2 && !act2 && act2_fall < 0) act2_fall = int'(col2);
      prev_act0 = act0;
      prev_act2 = act2;
      if (s_period == 0) begin
        if (fs1) begin
          s_period   = i;
          s_wrap_col = s_prev_col;
          s_wrap_row = s_prev_row;
        end else begin
          if (vs1) begin
            s_vs_cnt++;
            if (s_vs_col < 0) begin
              s_vs_col = int'(col1);
              s_vs_row = int'(row1);
            end
          end
          if (hs1 && row1 == 10'd0) begin
            if (s_hs_first < 0) s_hs_first = int'(col1);
            s_hs_last = int'(col1);
          end
        end
      end
      s_prev_col = int'(col1);
      s_prev_row = int'(row1);
    end

    check("hs_width", hs_cnt, 96);
    check("hs_first_col", hs_first, 656);
    check("hs_last_col", hs_last, 751);
    check("act_fall_col", act_fall, 640);
    check("ls_count_line", ls_cnt, 1);
    check("line2_col", col0, 0);
    check("line2_row", row0, 1);
    check("line2_ls", ls0, 1);
    check("line2_fs", fs0, 0);
    check("dly_hs_first", hs2_first, 658);
    check("dly_hs_last", hs2_last, 753);
    check("dly_act_rise", act2_rise, 2);
    check("dly_act_fall", act2_fall, 642);
    check("small_frame_len", s_period, 240);
    check("small_vs_cycles", s_vs_cnt, 40);
    check("small_vs_col", s_vs_col, 0);
    check("small_vs_row", s_vs_row, 9);
    check("small_wrap_col", s_wrap_col, 19);
    check("small_wrap_row", s_wrap_row, 11);
    check("small_hs_first", s_hs_first, 14);
    check("small_hs_last", s_hs_last, 16);

    // Enable gaps hold the counters.
    step(1);
    check("en_col_a", col0, 1);
    step(0);
    check("en_hold_col", col0, 1);
    step(0);
    check("en_hold_col2", col0, 1);
    check("en_hold_row", row0, 1);
    step(1);
    check("en_resume_col", col0, 2);

    // Line start followed by enable gap: strobe stays one cycle wide.
    for (int i = 0; i < 797; i++) step(1);
    check("pre_wrap_col", col0, 799);
    step(1);
    check("wrap_col", col0, 0);
    check("wrap_row", row0, 2);
    check("wrap_ls", ls0, 1);
    step(0);
    check("gap_ls_a", ls0, 0);
    check("gap_col", col0, 0);
    step(0);
    check("gap_ls_b", ls0, 0);
    step(1);
    check("gap_resume_col", col0, 1);
    check("gap_resume_ls", ls0, 0);

    // Reset in the middle of an HSync pulse.
    for (int i = 0; i < 699; i++) step(1);
    check("mid_col", col0, 700);
    check("mid_hs", hs0, 0);
    i_Rst = 1'b1;
    step(1);
    check("midrst_col", col0, 0);
    check("midrst_row", row0, 0);
    check("midrst_hs", hs0, 1);
    check("midrst_vs", vs0, 1);
    check("midrst_act", act0, 0);
    check("midrst_fs", fs0, 0);
    i_Rst = 1'b0;
    step(1);
    check("restart_col", col0, 0);
    check("restart_act", act0, 1);
    check("restart_fs", fs0, 1);
    check("restart_dly_fs", fs2, 1);
    step(1);
    check("restart_col1", col0, 1);
    check("restart_fs_off", fs0, 0);
    check("restart_hs", hs0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
